// File: rtl/sap_sequencer.sv
// sap_sequencer -- SAP-1 style micro-step sequencer.
//
// Walks the micro-steps T0..T5 of each instruction and decodes the control
// word for the datapath. Fetch (T0..T2) is the same for every instruction;
// execute (T3..T5) is decoded from the opcode.
//
// Parameters:
//   HLT_OPCODE  opcode that halts the sequencer (default 4'hF)
// Optional feature (compile-time macro):
//   SAP_JUMP_EN defines JMP (6) and JZ (7); without it both run as NOP and
//               pc_load is tied low.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   opcode     instruction register [7:4], valid from T3
//   a_zero     accumulator == 0 (used by JZ)
//   out_ready  display accepts the OUT value this cycle
//   ctrl       control word {hlt,pc_inc,pc_en,pc_load,mar_load,mem_en,
//              mem_we,ir_load,ir_en,a_load,a_en,b_load,adder_sub,adder_en,
//              out_valid}, bit 14 first
//   stage      current micro-step (0..5)
//   halted     sequencer stopped on HLT
module sap_sequencer #(
    parameter logic [3:0] HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        a_zero,
    input  logic        out_ready,
    output logic [14:0] ctrl,
    output logic [2:0]  stage,
    output logic        halted
);

    typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2,
                              T3 = 3'd3, T4 = 3'd4, T5 = 3'd5} stage_t;

    localparam logic [3:0] OP_LDA = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2,
                           OP_STA = 4'h3, OP_LDI = 4'h4, OP_OUT = 4'hE;
`ifdef SAP_JUMP_EN
    localparam logic [3:0] OP_JMP = 4'h6, OP_JZ = 4'h7;
`endif

    localparam logic [14:0] C_HLT     = 15'h4000, C_PC_INC  = 15'h2000,
                            C_PC_EN   = 15'h1000, C_PC_LOAD = 15'h0800,
                            C_MAR     = 15'h0400, C_MEM_EN  = 15'h0200,
                            C_MEM_WE  = 15'h0100, C_IR_LOAD = 15'h0080,
                            C_IR_EN   = 15'h0040, C_A_LOAD  = 15'h0020,
                            C_A_EN    = 15'h0010, C_B_LOAD  = 15'h0008,
                            C_SUB     = 15'h0004, C_ADD_EN  = 15'h0002,
                            C_OUTV    = 15'h0001;

    stage_t stage_q;
    logic   halted_q;

`ifndef SAP_JUMP_EN
    // a_zero only feeds JZ; keep it visibly consumed in this build.
    logic unused_a_zero;
    assign unused_a_zero = a_zero;
`endif

    // Control word depends only on stage, opcode, a_zero and halted, so an
    // OUT stall never lets out_ready ripple into the datapath controls.
    always_comb begin
        ctrl = '0;
        if (halted_q) begin
            ctrl = C_HLT;
        end else begin
            case (stage_q)
                T0: ctrl = C_PC_EN | C_MAR;
                T1: ctrl = C_PC_INC;
                T2: ctrl = C_MEM_EN | C_IR_LOAD;
                T3: begin
                    if (opcode == HLT_OPCODE) begin
                        ctrl = C_HLT;
                    end else begin
                        case (opcode)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = C_IR_EN | C_MAR;
                            OP_LDI: ctrl = C_IR_EN | C_A_LOAD;
                            OP_OUT: ctrl = C_A_EN | C_OUTV;
`ifdef SAP_JUMP_EN
                            OP_JMP: ctrl = C_IR_EN | C_PC_LOAD;
                            OP_JZ:  ctrl = a_zero ? (C_IR_EN | C_PC_LOAD) : '0;
`endif
                            default: ctrl = '0;
                        endcase
                    end
                end
                T4: begin
                    case (opcode)
                        OP_LDA:         ctrl = C_MEM_EN | C_A_LOAD;
                        OP_ADD, OP_SUB: ctrl = C_MEM_EN | C_B_LOAD;
                        OP_STA:         ctrl = C_A_EN | C_MEM_WE;
                        default:        ctrl = '0;
                    endcase
                end
                T5: begin
                    if (opcode == OP_ADD || opcode == OP_SUB)
                        ctrl = C_ADD_EN | C_A_LOAD | ((opcode == OP_SUB) ? C_SUB : 15'h0);
                end
                default: ctrl = '0;
            endcase
        end
    end

    // Stage walk. Halt freezes everything at T3 until reset; OUT holds T3
    // until the display accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q  <= T0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            case (stage_q)
                T0: stage_q <= T1;
                T1: stage_q <= T2;
                T2: stage_q <= T3;
                T3: begin
                    if (opcode == HLT_OPCODE) begin
                        halted_q <= 1'b1;
                    end else begin
                        case (opcode)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: stage_q <= T4;
                            OP_OUT:  stage_q <= out_ready ? T0 : T3;
                            default: stage_q <= T0;
                        endcase
                    end
                end
                T4: stage_q <= (opcode == OP_ADD || opcode == OP_SUB) ? T5 : T0;
                default: stage_q <= T0;
            endcase
        end
    end

    assign stage  = stage_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_sap_sequencer.sv
// Self-checking bench for sap_sequencer: directed instruction sequences,
// reset cases, then random instruction streams against an instruction-level
// model that lists the expected (stage, ctrl) per cycle.
module tb_sap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic        a_zero;
    logic        out_ready;
    logic [14:0] ctrl;
    logic [2:0]  stage;
    logic        halted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sap_sequencer #(.HLT_OPCODE(4'hF)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .a_zero(a_zero),
        .out_ready(out_ready), .ctrl(ctrl), .stage(stage), .halted(halted)
    );

    localparam logic [14:0] HLT = 15'h4000, PC_INC = 15'h2000, PC_EN = 15'h1000,
                            PC_LOAD = 15'h0800, MAR = 15'h0400, MEM_EN = 15'h0200,
                            MEM_WE = 15'h0100, IR_LOAD = 15'h0080, IR_EN = 15'h0040,
                            A_LOAD = 15'h0020, A_EN = 15'h0010, B_LOAD = 15'h0008,
                            SUB = 15'h0004, ADD_EN = 15'h0002, OUTV = 15'h0001;
    localparam logic [14:0] FETCH0 = PC_EN | MAR;

    int          exp_st[$];
    logic [14:0] exp_cw[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants: single bus driver, no write while loading MAR.
    task automatic invariants;
        int drv;
        drv = int'(ctrl[12]) + int'(ctrl[9]) + int'(ctrl[6]) + int'(ctrl[4]) + int'(ctrl[1]);
        chk("one_driver", 32'(drv <= 1), 1);
        chk("we_and_mar", 32'(ctrl[8] & ctrl[10]), 0);
        chk("stage_range", 32'(stage <= 3'd5), 1);
`ifndef SAP_JUMP_EN
        chk("pc_load_tied", 32'(ctrl[11]), 0);
`endif
    endtask

    task automatic push(input int st, input logic [14:0] cw);
        exp_st.push_back(st);
        exp_cw.push_back(cw);
    endtask

    // Instruction-level model: the full list of micro-steps an instruction
    // takes, including OUT stall cycles.
    task automatic plan(input logic [3:0] op, input logic az, input int stall);
        exp_st.delete();
        exp_cw.delete();
        push(0, PC_EN | MAR);
        push(1, PC_INC);
        push(2, MEM_EN | IR_LOAD);
        case (op)
            4'h0: begin push(3, IR_EN | MAR); push(4, MEM_EN | A_LOAD); end
            4'h1, 4'h2: begin
                push(3, IR_EN | MAR);
                push(4, MEM_EN | B_LOAD);
                push(5, ADD_EN | A_LOAD | ((op == 4'h2) ? SUB : 15'h0));
            end
            4'h3: begin push(3, IR_EN | MAR); push(4, A_EN | MEM_WE); end
            4'h4: push(3, IR_EN | A_LOAD);
            4'hE: for (int i = 0; i <= stall; i++) push(3, A_EN | OUTV);
            4'hF: push(3, HLT);
`ifdef SAP_JUMP_EN
            4'h6: push(3, IR_EN | PC_LOAD);
            4'h7: push(3, az ? (IR_EN | PC_LOAD) : 15'h0);
`endif
            default: push(3, 15'h0);
        endcase
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_stage"}, 32'(stage), 0);
        chk({tag, "_halted"}, 32'(halted), 0);
        chk({tag, "_ctrl"}, 32'(ctrl), 32'(FETCH0));
    endtask

    task automatic run_instr(input logic [3:0] op, input logic az, input int stall);
        int n;
        plan(op, az, stall);
        n = exp_st.size();
        opcode = op;
        a_zero = az;
        for (int k = 0; k < n; k++) begin
            if (op == 4'hE && exp_st[k] == 3) out_ready = (k == n - 1);
            else out_ready = 1'($urandom);
            chk($sformatf("op%0h_stage%0d", op, k), 32'(stage), 32'(exp_st[k]));
            // The T3 word of HLT itself is left unchecked; only the halted
            // state that follows is defined.
            if (!(op == 4'hF && k == n - 1))
                chk($sformatf("op%0h_ctrl%0d", op, k), 32'(ctrl), 32'(exp_cw[k]));
            chk($sformatf("op%0h_nohalt%0d", op, k), 32'(halted), 0);
            invariants();
            step();
        end
        if (op == 4'hF) begin
            for (int k = 0; k < 3; k++) begin
                opcode = 4'($urandom);
                out_ready = 1'($urandom);
                a_zero = 1'($urandom);
                chk("halt_flag", 32'(halted), 1);
                chk("halt_stage", 32'(stage), 3);
                chk("halt_ctrl", 32'(ctrl), 32'(HLT));
                step();
            end
            rst = 1'b1;
            step();
            check_reset_state("unhalt");
            rst = 1'b0;
        end
    endtask

    // Start an instruction, reset after ncyc cycles, confirm it was abandoned.
    task automatic reset_mid(input logic [3:0] op, input int ncyc);
        opcode = op;
        a_zero = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < ncyc; k++) step();
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        check_reset_state($sformatf("rstmid_op%0h", op));
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        opcode = 4'h0;
        a_zero = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check_reset_state("reset");
        rst = 1'b0;

        run_instr(4'h0, 1'b0, 0);   // LDA
        run_instr(4'h2, 1'b0, 0);   // SUB
        run_instr(4'h1, 1'b1, 0);   // ADD
        run_instr(4'h3, 1'b0, 0);   // STA
        run_instr(4'h4, 1'b0, 0);   // LDI
        run_instr(4'hE, 1'b0, 4);   // OUT, 4-cycle stall
        run_instr(4'hE, 1'b0, 0);   // OUT, no stall
        run_instr(4'h7, 1'b1, 0);   // JZ taken (or NOP)
        run_instr(4'h7, 1'b0, 0);   // JZ not taken
        run_instr(4'h6, 1'b0, 0);   // JMP (or NOP)
        run_instr(4'h9, 1'b1, 0);   // undefined
        run_instr(4'hF, 1'b0, 0);   // HLT then reset
        reset_mid(4'h3, 4);         // STA at T4 (write pending)
        reset_mid(4'hE, 6);         // OUT stalled at T3
        reset_mid(4'h2, 5);         // SUB at T5
        run_instr(4'h0, 1'b0, 0);

        for (int i = 0; i < 1500; i++)
            run_instr(4'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 3)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
